// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INS          = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or squash
// it to a bubble (NOP, valid cleared, PC fields left untouched).
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] ins_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc4_id,
    output logic        valid_id
);

    // Bubble outranks load; neither means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_id   <= NOP_INS;
            pc_id    <= 32'h0;
            pc4_id   <= 32'h0;
            valid_id <= 1'b0;
        end else if (bubble) begin
            ins_id   <= NOP_INS;
            valid_id <= 1'b0;
        end else if (load) begin
            ins_id   <= ins_in;
            pc_id    <= pc_in;
            pc4_id   <= pc4_in;
            valid_id <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, syscall-halt
// FSM, fetch counter and the IF/ID register.
//
// state  | meaning
// RUN    | fetching; stall/flush/redirect honoured
// HALTED | syscall halt; PC frozen, IF/ID held as bubble until go
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    input  logic               go,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ins_id,
    output logic [31:0]        pc_id,
    output logic [31:0]        pc4_id,
    output logic               valid_id,
    output logic               halted,
    output logic [31:0]        fetch_cnt
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_aligned;
    logic         if_bubble;
    logic         if_load;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign imem_addr        = pc[IMEM_AW+1:2];

    // IF/ID control: any halt, redirect or flush squashes; stall holds.
    always_comb begin
        if_bubble = (state == HALTED) || halt || redirect_en || flush;
        if_load   = !if_bubble && !stall;
    end

    // Halt FSM; halted mirrors the next state as a registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (go && !halt) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // PC update; a redirect is still taken on the cycle halt arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_RESET;
        end else if (state == RUN) begin
            if (redirect_en)
                pc <= redirect_aligned;
            else if (halt)
                pc <= pc;
            else if (flush || !stall)
                pc <= pc_plus4;
        end
    end

    // Count only real instructions entering IF/ID.
    always_ff @(posedge clk) begin
        if (rst)
            fetch_cnt <= 32'h0;
        else if (if_load)
            fetch_cnt <= fetch_cnt + 32'd1;
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (if_load),
        .bubble   (if_bubble),
        .ins_in   (imem_rdata),
        .pc_in    (pc),
        .pc4_in   (pc_plus4),
        .ins_id   (ins_id),
        .pc_id    (pc_id),
        .pc4_id   (pc4_id),
        .valid_id (valid_id)
    );

endmodule
